// File: rtl/ps2_key_tracker_if.sv
// Byte-receiver / application side bundle for ps2_key_tracker.
// The tracker is the slave; the byte source and the consumer logic form the master side.
interface ps2_key_tracker_if #(
  parameter int CNT_W = 3
);
  logic             recv;
  logic [7:0]       data;
  logic [8:0]       query_code;
  logic             query_hit;
  logic             pressed;
  logic [CNT_W-1:0] key_count;
  logic             make_evt;
  logic             break_evt;
  logic             repeat_evt;
  logic [8:0]       evt_code;
  logic             overflow;

  modport master (
    output recv,
    output data,
    output query_code,
    input  query_hit,
    input  pressed,
    input  key_count,
    input  make_evt,
    input  break_evt,
    input  repeat_evt,
    input  evt_code,
    input  overflow
  );

  modport slave (
    input  recv,
    input  data,
    input  query_code,
    output query_hit,
    output pressed,
    output key_count,
    output make_evt,
    output break_evt,
    output repeat_evt,
    output evt_code,
    output overflow
  );
endinterface

// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 scan-code parser feeding a NUM_KEYS-entry held-key slot table.
// Define PS2_KEY_TRACKER_TYPEMATIC_EN to report typematic repeats on repeat_evt.
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | no prefix pending
// ST_EXT     | E0 seen, next byte is an extended make or F0
// ST_BRK     | F0 seen, next byte is a normal break
// ST_EXT_BRK | E0 F0 seen, next byte is an extended break
// ST_PAUSE   | inside the E1 Pause sequence, skip_cnt bytes left
module ps2_key_tracker #(
  parameter int NUM_KEYS = 4,
  parameter int CNT_W    = 3
) (
  input  logic            clk,
  input  logic            rst,
  ps2_key_tracker_if.slave bus
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_EXT     = 3'd1;
  localparam logic [2:0] ST_BRK     = 3'd2;
  localparam logic [2:0] ST_EXT_BRK = 3'd3;
  localparam logic [2:0] ST_PAUSE   = 3'd4;

  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  logic [2:0]          state;
  logic [2:0]          state_nxt;
  logic [2:0]          skip_cnt;
  logic [2:0]          skip_cnt_nxt;

  logic                do_make;
  logic                do_break;
  logic [8:0]          code_in;

  logic [NUM_KEYS-1:0] slot_vld;
  logic [8:0]          slot_code [NUM_KEYS];
  logic [NUM_KEYS-1:0] hit_oh;
  logic [NUM_KEYS-1:0] free_oh;
  logic [NUM_KEYS-1:0] query_vec;
  logic                free_found;
  logic                held;
  logic                full;

  logic [CNT_W-1:0]    key_count;
  logic                make_evt;
  logic                break_evt;
  logic [8:0]          evt_code;
  logic                overflow;

  // Parser: decodes the byte stream into at most one make or break per recv.
  always_comb begin
    state_nxt    = state;
    skip_cnt_nxt = skip_cnt;
    do_make      = 1'b0;
    do_break     = 1'b0;
    code_in      = {1'b0, bus.data};
    if (bus.recv) begin
      case (state)
        ST_IDLE: begin
          case (bus.data)
            8'hE0: state_nxt = ST_EXT;
            8'hF0: state_nxt = ST_BRK;
            8'hE1: begin
              state_nxt    = ST_PAUSE;
              skip_cnt_nxt = PAUSE_SKIP;
            end
            8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: state_nxt = ST_IDLE;
            default: do_make = 1'b1;
          endcase
        end
        ST_EXT: begin
          case (bus.data)
            8'hF0: state_nxt = ST_EXT_BRK;
            8'hE0: state_nxt = ST_EXT;
            default: begin
              do_make   = 1'b1;
              code_in   = {1'b1, bus.data};
              state_nxt = ST_IDLE;
            end
          endcase
        end
        ST_BRK: begin
          do_break  = 1'b1;
          state_nxt = ST_IDLE;
        end
        ST_EXT_BRK: begin
          do_break  = 1'b1;
          code_in   = {1'b1, bus.data};
          state_nxt = ST_IDLE;
        end
        ST_PAUSE: begin
          skip_cnt_nxt = skip_cnt - 3'd1;
          if (skip_cnt_nxt == 3'd0) begin
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Slot lookup: match against the parsed code, the query code, and the lowest free slot.
  always_comb begin
    hit_oh     = '0;
    free_oh    = '0;
    query_vec  = '0;
    free_found = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      hit_oh[i]    = slot_vld[i] && (slot_code[i] == code_in);
      query_vec[i] = slot_vld[i] && (slot_code[i] == bus.query_code);
      if (!slot_vld[i] && !free_found) begin
        free_oh[i] = 1'b1;
        free_found = 1'b1;
      end
    end
  end

  assign held = |hit_oh;
  assign full = ~|free_oh;

`ifdef PS2_KEY_TRACKER_TYPEMATIC_EN
  logic repeat_evt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      skip_cnt  <= 3'd0;
      slot_vld  <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        slot_code[i] <= 9'h000;
      end
      key_count <= '0;
      make_evt  <= 1'b0;
      break_evt <= 1'b0;
      evt_code  <= 9'h000;
      overflow  <= 1'b0;
`ifdef PS2_KEY_TRACKER_TYPEMATIC_EN
      repeat_evt <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      skip_cnt  <= skip_cnt_nxt;
      make_evt  <= 1'b0;
      break_evt <= 1'b0;
`ifdef PS2_KEY_TRACKER_TYPEMATIC_EN
      repeat_evt <= 1'b0;
`endif
      if (do_make) begin
        if (held) begin
`ifdef PS2_KEY_TRACKER_TYPEMATIC_EN
          repeat_evt <= 1'b1;
          evt_code   <= code_in;
`endif
        end else if (!full) begin
          slot_vld <= slot_vld | free_oh;
          for (int i = 0; i < NUM_KEYS; i++) begin
            if (free_oh[i]) begin
              slot_code[i] <= code_in;
            end
          end
          key_count <= key_count + CNT_W'(1);
          make_evt  <= 1'b1;
          evt_code  <= code_in;
        end else begin
          overflow <= 1'b1;
        end
      end
      // Freed slots are left in place; the lowest-free rule reuses them.
      if (do_break && held) begin
        slot_vld  <= slot_vld & ~hit_oh;
        key_count <= key_count - CNT_W'(1);
        break_evt <= 1'b1;
        evt_code  <= code_in;
      end
    end
  end

  assign bus.query_hit = |query_vec;
  assign bus.pressed   = (key_count != '0);
  assign bus.key_count = key_count;
  assign bus.make_evt  = make_evt;
  assign bus.break_evt = break_evt;
  assign bus.evt_code  = evt_code;
  assign bus.overflow  = overflow;
`ifdef PS2_KEY_TRACKER_TYPEMATIC_EN
  assign bus.repeat_evt = repeat_evt;
`else
  assign bus.repeat_evt = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed plus randomized bench for ps2_key_tracker against a set-based reference model.
// Honours PS2_KEY_TRACKER_TYPEMATIC_EN when deciding whether repeats are expected.
module tb_ps2_key_tracker;
  localparam int NK = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  ps2_key_tracker_if #(.CNT_W(CW)) bus ();

  ps2_key_tracker #(.NUM_KEYS(NK), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: the held keys are just a set of codes; the prefix is tracked with flags.
  logic [8:0] m_held [$];
  logic       m_ext, m_brk, m_ovf;
  int         m_pause;
  logic [8:0] m_evt;
  logic       e_make, e_break, e_rep;

  logic [7:0] pool [10] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h15, 8'h1D, 8'h24, 8'h2D, 8'h75};
  logic [7:0] ign  [6]  = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int find_held(input logic [8:0] c);
    for (int i = 0; i < m_held.size(); i++) begin
      if (m_held[i] == c) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_held.delete();
    m_ext = 0; m_brk = 0; m_ovf = 0; m_pause = 0;
    m_evt = 9'h000; e_make = 0; e_break = 0; e_rep = 0;
  endtask

  task automatic model_make(input logic [8:0] c);
    if (find_held(c) >= 0) begin
`ifdef PS2_KEY_TRACKER_TYPEMATIC_EN
      e_rep = 1;
      m_evt = c;
`endif
    end else if (m_held.size() < NK) begin
      m_held.push_back(c);
      e_make = 1;
      m_evt  = c;
    end else begin
      m_ovf = 1;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    int idx;
    e_make = 0; e_break = 0; e_rep = 0;
    if (m_pause > 0) begin
      m_pause--;
    end else if (m_brk) begin
      idx = find_held({m_ext, b});
      if (idx >= 0) begin
        m_held.delete(idx);
        e_break = 1;
        m_evt   = {m_ext, b};
      end
      m_brk = 0;
      m_ext = 0;
    end else if (m_ext) begin
      if (b == 8'hF0) m_brk = 1;
      else if (b != 8'hE0) begin
        model_make({1'b1, b});
        m_ext = 0;
      end
    end else begin
      case (b)
        8'hE0: m_ext = 1;
        8'hF0: m_brk = 1;
        8'hE1: m_pause = 7;
        8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: ;
        default: model_make({1'b0, b});
      endcase
    end
  endtask

  task automatic check_outputs();
    chk("key_count", 32'(bus.key_count), 32'(m_held.size()));
    chk("pressed", 32'(bus.pressed), 32'(m_held.size() != 0));
    chk("make_evt", 32'(bus.make_evt), 32'(e_make));
    chk("break_evt", 32'(bus.break_evt), 32'(e_break));
    chk("repeat_evt", 32'(bus.repeat_evt), 32'(e_rep));
    chk("evt_code", 32'(bus.evt_code), 32'(m_evt));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
  endtask

  task automatic send(input logic [7:0] b);
    bus.recv = 1'b1;
    bus.data = b;
    model_byte(b);
    @(posedge clk);
    #1;
    bus.recv = 1'b0;
    bus.data = $urandom_range(0, 255);
    check_outputs();
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    e_make = 0; e_break = 0; e_rep = 0;
    check_outputs();
  endtask

  task automatic query(input logic [8:0] c);
    bus.query_code = c;
    #1;
    chk("query_hit", 32'(bus.query_hit), 32'(find_held(c) >= 0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_outputs();
  endtask

  initial begin
    int         act;
    logic [7:0] b;
    logic       ext;
    bus.recv = 1'b0;
    bus.data = 8'h00;
    bus.query_code = 9'h000;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    query(9'h000);
    query(9'h01C);

    // Single make then break.
    send(8'h1C);
    chk("tp1_make_code", 32'(bus.evt_code), 32'h01C);
    chk("tp1_count", 32'(bus.key_count), 32'd1);
    idle();
    send(8'hF0); send(8'h1C);
    chk("tp1_break_code", 32'(bus.evt_code), 32'h01C);
    chk("tp1_pressed", 32'(bus.pressed), 32'd0);
    idle();

    // Extended key and a non-extended query of the same byte.
    send(8'hE0); send(8'h75);
    chk("tp2_make_code", 32'(bus.evt_code), 32'h175);
    query(9'h075);
    chk("tp2_query_plain", 32'(bus.query_hit), 32'd0);
    query(9'h175);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("tp2_break_code", 32'(bus.evt_code), 32'h175);
    idle();

    // Fill the table, overflow, free slot 1 and refill.
    do_reset();
    send(8'h1C); send(8'h1B); send(8'h23); send(8'h2B); send(8'h34);
    chk("tp3_full_count", 32'(bus.key_count), 32'd4);
    chk("tp3_overflow", 32'(bus.overflow), 32'd1);
    query(9'h034);
    chk("tp3_dropped_query", 32'(bus.query_hit), 32'd0);
    send(8'hF0); send(8'h1B);
    send(8'h34);
    chk("tp3_refill_count", 32'(bus.key_count), 32'd4);
    query(9'h034);
    query(9'h01B);
    idle();

    // Pause sequence produces nothing, then a normal make.
    do_reset();
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'h1C);
    chk("tp4_make_after_pause", 32'(bus.make_evt), 32'd1);
    idle();

    // Typematic repeats.
    do_reset();
    send(8'h1C); send(8'h1C); send(8'h1C);
    chk("tp5_count", 32'(bus.key_count), 32'd1);
    idle();

    // Reset discards a pending E0 F0 prefix.
    send(8'hE0); send(8'hF0);
    do_reset();
    send(8'h1C);
    chk("tp6_make_not_break", 32'(bus.make_evt), 32'd1);
    chk("tp6_code", 32'(bus.evt_code), 32'h01C);
    idle();

    // Randomized stream.
    for (int it = 0; it < 600; it++) begin
      if (it % 120 == 119) do_reset();
      act = $urandom_range(0, 9);
      b   = pool[$urandom_range(0, 9)];
      ext = 1'($urandom_range(0, 1));
      if (act <= 3) begin
        if (ext) begin
          send(8'hE0);
          if ($urandom_range(0, 3) == 0) send(8'hE0);
        end
        send(b);
      end else if (act <= 6) begin
        if (m_held.size() > 0 && $urandom_range(0, 2) != 0) begin
          {ext, b} = m_held[$urandom_range(0, m_held.size() - 1)];
        end
        if (ext) send(8'hE0);
        send(8'hF0);
        send(b);
      end else if (act == 7) begin
        send(ign[$urandom_range(0, 5)]);
      end else if (act == 8) begin
        send(8'hE1);
        for (int k = 0; k < 7; k++) send(8'($urandom_range(0, 255)));
      end else begin
        for (int k = 0; k < 1 + int'($urandom_range(0, 2)); k++) idle();
      end
      query({1'($urandom_range(0, 1)), pool[$urandom_range(0, 9)]});
      if (m_held.size() > 0) query(m_held[$urandom_range(0, m_held.size() - 1)]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
- Parametrised successor to the single-key idle/pressed controller.
- Parses the PS/2 scan-code set 2 byte stream: make codes, F0 break prefix, E0 extended prefix, and the E1 Pause sequence.
- Tracks up to NUM_KEYS simultaneously held keys in a slot table.
- Sits between the PS/2 byte receiver and the VGA/application logic; provides held-state, key count, make/break event strobes and a membership query.

Parameters:
- NUM_KEYS, 4: number of key slots (1..16).
- CNT_W, 3: width of key_count; must satisfy 2^CNT_W > NUM_KEYS.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- recv  in  1  one-cycle strobe; data holds a valid received byte.
- data  in  8  received scan-code byte.
- query_code  in  9  {ext, code} to look up.
- query_hit  out  1  combinational; 1 when query_code matches any valid slot.
- pressed  out  1  1 when key_count != 0.
- key_count  out  CNT_W  number of valid slots.
- make_evt  out  1  one-cycle pulse: new key entered the table.
- break_evt  out  1  one-cycle pulse: held key removed from the table.
- evt_code  out  9  {ext, code} of the last make/break/repeat event; holds its value between events.
- overflow  out  1  sticky; a make was dropped because the table was full.
- repeat_evt  out  1  typematic repeat pulse (see Optional Feature).

Behaviour:
- Reset: clock and reset are fixed — one clock (clk); reset (rst) is synchronous and active-high. All slots are invalid, parser is in IDLE, key_count=0, pressed=0, make_evt=break_evt=repeat_evt=0, evt_code=9'h000, overflow=0. rst mid-sequence discards any partial prefix.
- Parser FSM (advances only on recv=1; recv=0 holds state):
  - IDLE: E0 -> EXT; F0 -> BRK; E1 -> PAUSE (skip counter=7); bytes AA, FA, FE, EE, 00, FF are ignored and stay in IDLE; any other byte is a make of {0,data}.
  - EXT: F0 -> EXT_BRK; E0 -> stay in EXT; any other byte is a make of {1,data}, then IDLE.
  - BRK: any byte is a break of {0,data}, then IDLE.
  - EXT_BRK: any byte is a break of {1,data}, then IDLE.
  - PAUSE: each byte decrements the skip counter; when it reaches 0, go to IDLE. No table change, no events.
- Make handling:
  - Code already held: no slot change, make_evt=0; repeat handled per macro.
  - Free slot exists: write to the lowest-index free slot, key_count+1, make_evt=1, evt_code=code.
  - Table full: overflow<=1, no event, table unchanged.
- Break handling:
  - Code held: invalidate its slot, key_count-1, break_evt=1, evt_code=code.
  - Code not held: ignored, no event.
- Latency: table, key_count, pressed and event pulses update on the clock edge that samples the final byte's recv. Pulses last exactly one cycle.
- Slots are not compacted; a freed slot is reused by the lowest-index rule.
- overflow clears only on rst.
- query_hit is purely combinational from the current table; it reflects an update in the cycle after the edge that made it.

Optional Feature:
- Macro: PS2_KEY_TRACKER_TYPEMATIC_EN.
- Defined: a make of an already-held code pulses repeat_evt for one cycle and sets evt_code to that code.
- Undefined: repeat_evt is tied to 0, and a repeated make leaves evt_code unchanged.

Test Plan:
- Bytes 1C -> make_evt pulse, evt_code=0x01C, key_count=1, pressed=1. Then F0,1C -> break_evt, evt_code=0x01C, key_count=0, pressed=0.
- Bytes E0,75 then E0,F0,75 -> make_evt with evt_code=0x175, then break_evt with evt_code=0x175. A query of 0x075 during the hold returns query_hit=0.
- NUM_KEYS=4; makes 1C,1B,23,2B,34 -> key_count=4, overflow=1 after 34, query 0x034 gives hit=0. Then F0,1B followed by make 34 -> 34 occupies slot 1, key_count=4.
- Pause sequence E1,14,77,E1,F0,14,F0,77, then make 1C -> no events during the 8 Pause bytes, then make_evt with evt_code=0x01C.
- Bytes 1C,1C,1C -> key_count=1, a single make_evt. repeat_evt pulses twice with the macro defined, 0 without.
- Bytes E0,F0 then rst=1 for one cycle, then 1C -> slot table empty after reset, and 1C is treated as a make of 0x01C, not a break.
